// File: rtl/scale_mux_pkg.sv
// Shared types and defaults for the scale_mux_arb block.
package scale_mux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic {
        SRC_B = 1'b0,
        SRC_A = 1'b1
    } src_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/scale_mux.sv
// Two-way data selector: y_data follows a_data when sel_a is high, else b_data.
module scale_mux
    import scale_mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             sel_a,
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    output logic [WIDTH-1:0] y_data
);

    assign y_data = sel_a ? a_data : b_data;

endmodule

// File: rtl/scale_mux_arb.sv
// Round-robin two-source arbiter feeding a one-entry registered output stage.
// Optional per-source saturating transfer counters: define SCALE_MUX_ARB_CNT_EN.
module scale_mux_arb
    import scale_mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
`ifdef SCALE_MUX_ARB_CNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
`ifdef SCALE_MUX_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
`endif
);

    state_e           state_q;
    src_e             out_src_q;
    src_e             last_q;
    logic [WIDTH-1:0] out_data_q;

    logic             req;
    logic             load;
    logic             sel_a;
    logic             grant_a;
    src_e             grant_src;
    logic [WIDTH-1:0] mux_y;

    assign req = a_valid | b_valid;

    // Gating with rst_ keeps both readies low while reset is held.
    assign load = rst_ & req & ((state_q == EMPTY) | out_ready);

    // sel_a defaults to A when nobody requests; B wins only if it asks
    // and A is absent or A was served last.
    assign sel_a     = ~b_valid | (a_valid & (last_q == SRC_B));
    assign grant_a   = a_valid & sel_a;
    assign grant_src = grant_a ? SRC_A : SRC_B;

    assign a_ready = load & grant_a;
    assign b_ready = load & ~grant_a;

    scale_mux #(
        .WIDTH(WIDTH)
    ) u_mux (
        .sel_a (sel_a),
        .a_data(a_data),
        .b_data(b_data),
        .y_data(mux_y)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_src_q  <= SRC_B;
            last_q     <= SRC_B;
        end else if (load) begin
            state_q    <= FULL;
            out_data_q <= mux_y;
            out_src_q  <= grant_src;
            last_q     <= grant_src;
        end else if (out_ready) begin
            state_q    <= EMPTY;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef SCALE_MUX_ARB_CNT_EN
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (a_ready && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + CNT_W'(1);
        if (b_ready && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_scale_mux_arb.sv
// Self-checking bench for scale_mux_arb; counter checks active with SCALE_MUX_ARB_CNT_EN.
module tb_scale_mux_arb;

    logic       clk = 1'b0;
    logic       rst_;
    logic       a_valid, b_valid, out_ready;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, out_valid, out_src;
    logic [7:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the output register and arbitration history.
    bit       m_valid;
    bit [7:0] m_data;
    bit       m_src;
    bit       m_last_a;
    int       m_ca, m_cb;

    always #5 clk = ~clk;

`ifdef SCALE_MUX_ARB_CNT_EN
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  n_cnt_a, n_cnt_b;
    logic        n_a_ready, n_b_ready, n_out_valid, n_out_src;
    logic [7:0]  n_out_data;
`endif

    scale_mux_arb #(
        .WIDTH(8)
    ) u_dut (
        .clk      (clk),
        .rst_     (rst_),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready)
`ifdef SCALE_MUX_ARB_CNT_EN
        ,
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b)
`endif
    );

`ifdef SCALE_MUX_ARB_CNT_EN
    scale_mux_arb #(
        .WIDTH(8),
        .CNT_W(2)
    ) u_dut_n (
        .clk      (clk),
        .rst_     (rst_),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_ready  (n_a_ready),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_ready  (n_b_ready),
        .out_valid(n_out_valid),
        .out_data (n_out_data),
        .out_src  (n_out_src),
        .out_ready(out_ready),
        .cnt_a    (n_cnt_a),
        .cnt_b    (n_cnt_b)
    );
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_valid  = 0;
        m_data   = 8'h00;
        m_src    = 0;
        m_last_a = 0;
        m_ca     = 0;
        m_cb     = 0;
    endfunction

    // Predicted handshake for the current inputs and model state.
    function automatic void predict(output bit ld, output bit ga);
        bit req = a_valid | b_valid;
        ld = rst_ && req && (!m_valid || out_ready);
        if (a_valid && b_valid) ga = !m_last_a;
        else                    ga = a_valid;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic compare();
        bit ld, ga;
        predict(ld, ga);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_src", out_src, m_src);
        end
        chk("a_ready", a_ready, ld && ga);
        chk("b_ready", b_ready, ld && !ga);
`ifdef SCALE_MUX_ARB_CNT_EN
        chk("cnt_a", cnt_a, sat(m_ca, 65535));
        chk("cnt_b", cnt_b, sat(m_cb, 65535));
        chk("cnt_a_narrow", n_cnt_a, sat(m_ca, 3));
        chk("cnt_b_narrow", n_cnt_b, sat(m_cb, 3));
`endif
    endtask

    task automatic drive(input logic r, input logic av, input logic [7:0] ad,
                         input logic bv, input logic [7:0] bd, input logic ordy);
        rst_      = r;
        a_valid   = av;
        a_data    = ad;
        b_valid   = bv;
        b_data    = bd;
        out_ready = ordy;
        if (!r) model_reset();
        #1;
    endtask

    // Check, advance one clock edge, then move the model.
    task automatic cycle();
        bit ld, ga;
        compare();
        predict(ld, ga);
        @(posedge clk);
        if (rst_) begin
            if (ld) begin
                m_data   = ga ? a_data : b_data;
                m_src    = ga;
                m_last_a = ga;
                m_valid  = 1;
                if (ga) m_ca++;
                else    m_cb++;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        drive(0, 1, 8'hA5, 1, 8'h5A, 1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        cycle();
    endtask

    logic [7:0] exp_seq [4];
    logic       exp_src [4];

    initial begin
        exp_seq = '{8'hAA, 8'h55, 8'hAA, 8'h55};
        exp_src = '{1'b1, 1'b0, 1'b1, 1'b0};
        model_reset();
        rst_ = 0; a_valid = 0; b_valid = 0; a_data = 0; b_data = 0; out_ready = 0;
        @(posedge clk);
        #1;

        // Reset with both sources requesting.
        do_reset();

        // Single source A.
        drive(1, 1, 8'h3C, 0, 8'h00, 1);
        chk("single_a_ready", a_ready, 1'b1);
        cycle();
        drive(1, 0, 8'h00, 0, 8'h00, 1);
        chk("single_out_data", out_data, 8'h3C);
        chk("single_out_src", out_src, 1'b1);
        chk("single_out_valid", out_valid, 1'b1);
        cycle();

        // Contention alternates starting with A after reset.
        do_reset();
        for (int unsigned i = 0; i < 4; i++) begin
            drive(1, 1, 8'hAA, 1, 8'h55, 1);
            cycle();
            chk("contend_data", out_data, exp_seq[i]);
            chk("contend_src", out_src, exp_src[i]);
        end

        // Backpressure holds the word and blocks B.
        do_reset();
        drive(1, 0, 8'h00, 1, 8'h11, 1);
        cycle();
        for (int unsigned i = 0; i < 3; i++) begin
            drive(1, 0, 8'h00, 1, 8'h22, 0);
            chk("bp_b_ready", b_ready, 1'b0);
            chk("bp_out_data", out_data, 8'h11);
            cycle();
        end
        drive(1, 0, 8'h00, 1, 8'h22, 1);
        chk("bp_release_b_ready", b_ready, 1'b1);
        cycle();
        drive(1, 0, 8'h00, 0, 8'h00, 1);
        chk("bp_release_data", out_data, 8'h22);
        cycle();
        chk("drain_valid", out_valid, 1'b0);

`ifdef SCALE_MUX_ARB_CNT_EN
        do_reset();
        for (int unsigned i = 0; i < 6; i++) begin
            drive(1, 1, 8'(i), 0, 8'h00, 1);
            cycle();
        end
        chk("lit_cnt_a_6", cnt_a, 16'd6);
        chk("lit_cnt_a_narrow_sat", n_cnt_a, 2'd3);
        do_reset();
        for (int unsigned i = 0; i < 7; i++) begin
            drive(1, i < 5, 8'h01, i >= 5, 8'h02, 1);
            cycle();
        end
        chk("lit_cnt_a_5", cnt_a, 16'd5);
        chk("lit_cnt_b_2", cnt_b, 16'd2);
`endif

        // Randomised traffic with occasional resets.
        for (int unsigned i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 3) != 0), 8'($urandom),
                  ($urandom_range(0, 2) != 0), 8'($urandom),
                  ($urandom_range(0, 3) != 0));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
